// File: rtl/if_stage_param.sv
// ============================================================================
//  Module   : if_stage_param
//  Purpose  : Instruction-fetch stage with PC register, redirect, flush and
//             an integrated IF/ID pipeline register carrying a valid bit.
//  Options  : IF_STAGE_PERF_EN adds fetch/stall/bubble performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_param #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 20,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               flush,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] C_PC_STEP  = PC_W'(PC_STEP);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic               if_id_valid_q, if_id_valid_d;

  logic w_squash;
  logic w_capture;

  assign w_squash  = redirect_valid | flush;
  assign w_capture = ~w_squash & pc_write;

  // Redirect beats the hazard stall: a resolved branch must never be lost.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (pc_write) begin
      pc_d = pc_q + C_PC_STEP;
    end
  end

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (w_squash) begin
      if_id_pc_d    = '0;
      if_id_instr_d = '0;
      if_id_valid_d = 1'b0;
    end else if (pc_write) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= C_RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Counters wrap silently at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (w_capture) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (~pc_write & ~redirect_valid) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (w_squash) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage_param.sv
// ============================================================================
//  Module   : tb_if_stage_param
//  Purpose  : Self-checking scoreboard bench for if_stage_param (defaults).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage_param;

  typedef struct packed {
    logic       rs;
    logic       pw;
    logic       rv;
    logic       fl;
    logic [7:0] rpc;
  } stim_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  ipc;
    logic [19:0] instr;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        flush = 1'b0;
  logic [7:0]  imem_addr;
  logic [19:0] imem_rdata;
  logic [7:0]  pc;
  logic [7:0]  if_id_pc;
  logic [19:0] if_id_instr;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Asynchronous-read memory: word[i] = i + 0x100.
  assign imem_rdata = 20'(imem_addr) + 20'h100;

  if_stage_param dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  function automatic stim_t mk(logic rs, logic pw, logic rv, logic fl, logic [7:0] rpc);
    stim_t s;
    s.rs = rs; s.pw = pw; s.rv = rv; s.fl = fl; s.rpc = rpc;
    return s;
  endfunction

  function automatic exp_t ex(logic [7:0] p, logic [7:0] ip, logic [19:0] ins, logic v);
    exp_t e;
    e.pc = p; e.ipc = ip; e.instr = ins; e.valid = v;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.pc = pc; a.ipc = if_id_pc; a.instr = if_id_instr; a.valid = if_id_valid;
    return a;
  endfunction

  task automatic apply(stim_t s);
    rst            = s.rs;
    pc_write       = s.pw;
    redirect_valid = s.rv;
    flush          = s.fl;
    redirect_pc    = s.rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(1, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h00, 8'h00, 20'h0, 0));
    s.push_back(mk(1, 1, 1, 0, 8'h55)); sb_q.push_back(ex(8'h00, 8'h00, 20'h0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_free_run();
    stim_t s[$];
    exp_t  got, want;
    for (int k = 0; k < 5; k++) begin
      s.push_back(mk(0, 1, 0, 0, 8'h00));
      sb_q.push_back(ex(8'(k + 1), 8'(k), 20'h100 + 20'(k), 1));
    end
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL free_run[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    exp_t  got, want;
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk(0, 0, 0, 0, 8'h00)); sb_q.push_back(ex(8'h05, 8'h04, 20'h104, 1));
    end
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h06, 8'h05, 20'h105, 1));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h07, 8'h06, 20'h106, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL stall[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_redirect_stall();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, 0, 1, 0, 8'h40)); sb_q.push_back(ex(8'h40, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h41, 8'h40, 20'h140, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL redirect_stall[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, 1, 1, 0, 8'h09)); sb_q.push_back(ex(8'h09, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 1, 8'h00)); sb_q.push_back(ex(8'h0a, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h0b, 8'h0a, 20'h10a, 1));
    s.push_back(mk(0, 0, 0, 1, 8'h00)); sb_q.push_back(ex(8'h0b, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 0, 0, 0, 8'h00)); sb_q.push_back(ex(8'h0b, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h0c, 8'h0b, 20'h10b, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL flush[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, 1, 1, 0, 8'h10)); sb_q.push_back(ex(8'h10, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 1, 0, 8'h20)); sb_q.push_back(ex(8'h20, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 1, 1, 8'h30)); sb_q.push_back(ex(8'h30, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h31, 8'h30, 20'h130, 1));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h32, 8'h31, 20'h131, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(0, 1, 1, 0, 8'hfe)); sb_q.push_back(ex(8'hfe, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'hff, 8'hfe, 20'h1fe, 1));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h00, 8'hff, 20'h1ff, 1));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h01, 8'h00, 20'h100, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t s[$];
    exp_t  got, want;
    s.push_back(mk(1, 0, 1, 0, 8'h33)); sb_q.push_back(ex(8'h00, 8'h00, 20'h0, 0));
    s.push_back(mk(1, 1, 0, 1, 8'h00)); sb_q.push_back(ex(8'h00, 8'h00, 20'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 8'h00)); sb_q.push_back(ex(8'h01, 8'h00, 20'h100, 1));
    foreach (s[i]) begin
      apply(s[i]);
      tick();
      got  = sample();
      want = sb_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL mid_reset[%0d]: got pc=%h ifid=(%h,%h,%b) expected pc=%h ifid=(%h,%h,%b)",
                 i, got.pc, got.ipc, got.instr, got.valid, want.pc, want.ipc, want.instr, want.valid);
      end
    end
  endtask

`ifdef IF_STAGE_PERF_EN
  task automatic test_perf();
    apply(mk(1, 1, 0, 0, 8'h00));
    tick();
    tests_run++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_bubble_cnt} !== 96'd0) begin
      tests_failed++;
      $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0",
               perf_fetch_cnt, perf_stall_cnt, perf_bubble_cnt);
    end
    for (int k = 0; k < 10; k++) begin
      apply(mk(0, 1, 0, 0, 8'h00));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 0, 0, 8'h00));
      tick();
    end
    apply(mk(0, 1, 1, 0, 8'h20));
    tick();
    apply(mk(0, 0, 1, 0, 8'h00));
    tests_run++;
    if (perf_fetch_cnt !== 32'd10) begin
      tests_failed++;
      $display("FAIL perf_fetch: got %0d expected 10", perf_fetch_cnt);
    end
    tests_run++;
    if (perf_stall_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt);
    end
    tests_run++;
    if (perf_bubble_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL perf_bubble: got %0d expected 1", perf_bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
`ifdef IF_STAGE_PERF_EN
    test_perf();
`endif
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
